decimal_digit_entry: RTL
========================

# decimal_digit_entry

Sequential decimal-to-binary operand entry: the user sets one BCD digit on four switches and presses a debounced enter button; the block accumulates digits most-significant first into a saturating binary value (value = value*10 + digit). It is the input-side counterpart of the binary-to-decimal seven-segment display path. It feeds operands A/B of the switch adder in place of raw 7-bit switch binary. A clear button restarts entry.

## Interface
- DEBOUNCE_CYCLES, 250000, stable-level cycles required before a button change is accepted (≥2)
- MAX_DIGITS, 2, digits accepted before entry completes (1..3)
- MAX_VALUE, 99, saturation limit of value
- VALUE_W, 7, width of value (must hold MAX_VALUE)
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- digit_sw  input  4  raw digit switches, BCD, asynchronous to clk
- enter_btn  input  1  raw enter button, active-high, bouncing
- clear_btn  input  1  raw clear button, active-high, bouncing
- value  output  VALUE_W  accumulated binary value
- digit_count  output  2  digits accepted so far
- value_valid  output  1  high while entry is complete (state DONE)
- done  output  1  one-cycle pulse on entering DONE
- overflow  output  1  sticky; set when an accumulation saturated
- digit_err  output  1  one-cycle pulse on rejected digit (only with ENTRY_ERROR_EN)

## Operation
- Input conditioning: enter_btn, clear_btn, digit_sw each pass a 2-FF synchronizer. Each button has its own debouncer: counter cleared whenever synchronized level ≠ stable level; when counter reaches DEBOUNCE_CYCLES-1 the stable level takes the synchronized level. enter_evt/clear_evt = stable rising edge (combinational stable & ~stable_q), one cycle.
- Digit is sampled from synchronized digit_sw in the enter_evt cycle.
- FSM states IDLE (digit_count=0), ENTRY (0<digit_count<MAX_DIGITS), DONE.
- IDLE/ENTRY + enter_evt with valid digit: value ← min((value<<3)+(value<<1)+digit, MAX_VALUE); overflow set if unclamped sum > MAX_VALUE; digit_count+1; if new count = MAX_DIGITS → DONE, value_valid=1, done pulses; else → ENTRY.
- Intermediate arithmetic is VALUE_W+4 bits wide; no truncation before compare.
- DONE + enter_evt: ignored, no output change.
- clear_evt in any state: value=0, digit_count=0, overflow=0, value_valid=0 → IDLE.
- clear_evt and enter_evt same cycle: clear wins; digit discarded.
- Both buttons held: each debounced independently; only rising edges act.

## Timing
- Reset: value=0, digit_count=0, value_valid=0, done=0, overflow=0, digit_err=0; FSM IDLE; debouncer stable levels 0, counters 0; synchronizers 0.
- Raw button high first sampled at edge 0 and held: sync high after edge 1; stable high after edge 1+DEBOUNCE_CYCLES; value/digit_count/FSM update at edge 2+DEBOUNCE_CYCLES.
- digit_sw must be stable ≥3 cycles before that update edge.
- done and digit_err are single-cycle, registered, asserted the same edge value updates.
- Glitch shorter than DEBOUNCE_CYCLES on a button: no event.
- rst mid-debounce or mid-entry: immediate return to reset values; a button held through reset deassertion produces an event only after a fresh DEBOUNCE_CYCLES.

## Configuration
- ENTRY_ERROR_EN defined: digit > 9 on enter_evt is rejected — no state/value/count change, digit_err pulses one cycle.
- ENTRY_ERROR_EN undefined: digit_err tied 0; digit > 9 is clamped to 9 and accepted as a normal digit.

## Test plan
- DEBOUNCE_CYCLES=4: reset, enter digit 4 then 7 → value=47, digit_count=2, value_valid=1, done one cycle at edge 6 after second press sampled.
- Enter 9, 9 → value=99, overflow=0; MAX_VALUE=50 build: enter 6, 0 → value=50, overflow=1.
- Enter bounce: 3-cycle high pulses separated by lows, then stable high → exactly one digit accepted.
- digit_sw=12 + enter: with ENTRY_ERROR_EN → digit_err pulse, value=0, digit_count=0; without → value=9, digit_count=1.
- After DONE with 47, third enter with 5 → value stays 47; simultaneous clear+enter → value=0, digit_count=0, IDLE.
- rst asserted asynchronously mid-entry (value=3) → all outputs 0 immediately without clock edge.

Source files
------------

// File: rtl/decimal_digit_entry_if.sv
// rtl/decimal_digit_entry_if.sv - switch/button inputs and entry result outputs of decimal_digit_entry
interface decimal_digit_entry_if #(
    parameter int VALUE_W = 7
);
    logic [3:0]         digit_sw;
    logic               enter_btn;
    logic               clear_btn;
    logic [VALUE_W-1:0] value;
    logic [1:0]         digit_count;
    logic               value_valid;
    logic               done;
    logic               overflow;
    logic               digit_err;

    modport master (
        output digit_sw, enter_btn, clear_btn,
        input  value, digit_count, value_valid, done, overflow, digit_err
    );

    modport slave (
        input  digit_sw, enter_btn, clear_btn,
        output value, digit_count, value_valid, done, overflow, digit_err
    );
endinterface

// File: rtl/decimal_digit_entry.sv
// rtl/decimal_digit_entry.sv - debounced BCD digit entry into saturating binary value; option macro ENTRY_ERROR_EN
module decimal_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_DIGITS      = 2,
    parameter int MAX_VALUE       = 99,
    parameter int VALUE_W         = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    decimal_digit_entry_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SUM_W = VALUE_W + 4;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SUM_W-1:0]   MAX_SUM   = SUM_W'(MAX_VALUE);
    localparam logic [VALUE_W-1:0] MAX_VAL_V = VALUE_W'(MAX_VALUE);
    localparam logic [1:0]         MAX_CNT   = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    logic             enter_s1, enter_s2, clear_s1, clear_s2;
    logic [3:0]       digit_s1, digit_s2;
    logic [CNT_W-1:0] enter_cnt, clear_cnt;
    logic             enter_stable, enter_stable_q, clear_stable, clear_stable_q;
    logic             enter_evt, clear_evt;

    state_t             state, state_nxt;
    logic [VALUE_W-1:0] value_r, value_nxt;
    logic [1:0]         count_r, count_nxt;
    logic               ovf_r, ovf_nxt, done_r, done_nxt, err_r, err_nxt;
    logic [3:0]         digit_eff;
    logic               digit_ok;
    logic [SUM_W-1:0]   value_ext, sum;

    // two-flop synchronizers for the asynchronous switches and buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_s1 <= 1'b0; enter_s2 <= 1'b0;
            clear_s1 <= 1'b0; clear_s2 <= 1'b0;
            digit_s1 <= '0;   digit_s2 <= '0;
        end else begin
            enter_s1 <= bus.enter_btn; enter_s2 <= enter_s1;
            clear_s1 <= bus.clear_btn; clear_s2 <= clear_s1;
            digit_s1 <= bus.digit_sw;  digit_s2 <= digit_s1;
        end
    end

    // enter debouncer: count while synchronized level differs, adopt it after DEBOUNCE_CYCLES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_cnt      <= '0;
            enter_stable   <= 1'b0;
            enter_stable_q <= 1'b0;
        end else begin
            enter_stable_q <= enter_stable;
            if (enter_s2 == enter_stable) begin
                enter_cnt <= '0;
            end else if (enter_cnt == CNT_LAST) begin
                enter_stable <= enter_s2;
                enter_cnt    <= '0;
            end else begin
                enter_cnt <= enter_cnt + CNT_W'(1);
            end
        end
    end

    // clear debouncer, identical to the enter one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_cnt      <= '0;
            clear_stable   <= 1'b0;
            clear_stable_q <= 1'b0;
        end else begin
            clear_stable_q <= clear_stable;
            if (clear_s2 == clear_stable) begin
                clear_cnt <= '0;
            end else if (clear_cnt == CNT_LAST) begin
                clear_stable <= clear_s2;
                clear_cnt    <= '0;
            end else begin
                clear_cnt <= clear_cnt + CNT_W'(1);
            end
        end
    end

    assign enter_evt = enter_stable & ~enter_stable_q;
    assign clear_evt = clear_stable & ~clear_stable_q;

`ifdef ENTRY_ERROR_EN
    assign digit_eff = digit_s2;
    assign digit_ok  = (digit_s2 <= 4'd9);
`else
    assign digit_eff = (digit_s2 > 4'd9) ? 4'd9 : digit_s2;
    assign digit_ok  = 1'b1;
`endif

    // value*10 + digit in a widened datapath so the saturation compare sees the true sum
    assign value_ext = {4'b0000, value_r};
    assign sum       = (value_ext << 3) + (value_ext << 1) + SUM_W'(digit_eff);

    // entry state and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            value_r <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            value_r <= value_nxt;
            count_r <= count_nxt;
            ovf_r   <= ovf_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
        end
    end

    // next-state: clear has priority, enter accumulates until MAX_DIGITS then is ignored
    always_comb begin
        state_nxt = state;
        value_nxt = value_r;
        count_nxt = count_r;
        ovf_nxt   = ovf_r;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (clear_evt) begin
            state_nxt = IDLE;
            value_nxt = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (enter_evt && state != DONE) begin
            if (!digit_ok) begin
                err_nxt = 1'b1;
            end else begin
                if (sum > MAX_SUM) begin
                    value_nxt = MAX_VAL_V;
                    ovf_nxt   = 1'b1;
                end else begin
                    value_nxt = sum[VALUE_W-1:0];
                end
                count_nxt = count_r + 2'd1;
                if (count_nxt == MAX_CNT) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ENTRY;
                end
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.digit_count = count_r;
    assign bus.value_valid = (state == DONE);
    assign bus.done        = done_r;
    assign bus.overflow    = ovf_r;
    assign bus.digit_err   = err_r;
endmodule
